dds_cmd_ctrl: RTL
=================

DDS_CMD_CTRL -- requirements
Module: dds_cmd_ctrl

Interface
REQ-001 SHALL provide parameter CHANNELS, default 2, number of DDS channels (1..16).
REQ-002 SHALL provide parameter ACC_W, default 32, phase-accumulator adder width in bits (multiple of 8, 8..64).
REQ-003 SHALL provide parameter ADDER_RST, default 1073741, per-channel adder value after reset.
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 2000000, inter-byte timeout in clk cycles (>=2).
REQ-005 SHALL provide port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL provide port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide ports rx_data (input, 8, received UART byte) and rx_valid (input, 1, one-cycle byte strobe).
REQ-008 SHALL provide port wf, output, CHANNELS*8, per-channel waveform select; channel n at bits [8n+7:8n].
REQ-009 SHALL provide port adder, output, CHANNELS*ACC_W, per-channel adder value; channel n at [ACC_W*n+ACC_W-1:ACC_W*n].
REQ-010 SHALL provide ports upd (output, CHANNELS, one-cycle per-channel commit pulse), err (output, 1, one-cycle frame-error pulse) and busy (output, 1, high while a frame is in progress).

Function
REQ-011 SHALL parse frames: CMD, CH, WF, then for CMD=0x01 (SETFREQ) ACC_W/8 adder bytes MSB first; CMD=0x02 (SETWF) carries no adder bytes.
REQ-012 SHALL use states IDLE -> CHAN -> WAVE -> ACC (SETFREQ only, byte counter 0..ACC_W/8-1) -> [CHK] -> IDLE; each byte advances only on rx_valid.
REQ-013 SHALL silently ignore any byte other than 0x01/0x02 received in IDLE (no err, stay IDLE).
REQ-014 SHALL collect WF/adder in shadow registers; outputs change only on commit of a complete valid frame, never byte by byte.
REQ-015 SHALL commit on the cycle after the final byte's rx_valid: target channel's wf (and adder for SETFREQ) update and upd[CH] pulses high for exactly one cycle; other channels untouched.
REQ-016 SHALL on CH >= CHANNELS consume the full frame, then pulse err one cycle after its final byte, with no commit.
REQ-017 SHALL count cycles since the last accepted byte while not IDLE; on reaching TIMEOUT_CYC return to IDLE, discard shadow data, pulse err.
REQ-018 SHALL give rx_valid priority over timeout when both occur in the same cycle: byte accepted, counter cleared.
REQ-019 SHALL hold busy high from the cycle after an accepted CMD byte until the cycle of commit/err/return to IDLE.

Reset
REQ-020 SHALL on rst low immediately set state IDLE, wf all 0, every adder ADDER_RST, upd 0, err 0, busy 0, timer 0, shadow 0; a frame in progress is discarded.

Configuration
REQ-021 SHALL, with CMD_CHECKSUM_EN defined, require a trailing CHK byte equal to the XOR of all preceding frame bytes; mismatch pulses err with no commit.
REQ-022 SHALL, without CMD_CHECKSUM_EN, omit CHK state and XOR logic; frame ends at last WF/adder byte.

Structure
REQ-023 SHALL place command codes (0x01, 0x02) and the parser state enum in shared package dds_ctrl_pkg.
REQ-024 SHALL implement the inter-byte timer as sub-module dds_byte_timer (inputs clk, rst, clear, run; output expired).

Verification (CHANNELS=2, ACC_W=32, TIMEOUT_CYC=100)
REQ-025 SHALL check macro off: bytes 01 01 03 12 34 56 78 -> one cycle after last byte wf[15:8]=03, adder[63:32]=0x12345678, upd=2'b10 one cycle; channel 0 still 0/1073741.
REQ-026 SHALL check macro on: 01 01 03 12 34 56 78 0B -> commit as above; same frame with CHK=0x0C -> err pulse, no upd, outputs unchanged.
REQ-027 SHALL check 02 05 07 (macro off) -> err one cycle after last byte, no upd; stray bytes 0xFF 0x00 in IDLE -> no err, busy low.
REQ-028 SHALL check 01 00 05 then 100 idle cycles -> err pulse, busy low, outputs unchanged; subsequent full frame commits normally; byte on exactly cycle 100 -> accepted, no err.
REQ-029 SHALL check rst low after 01 00 05 12 -> all outputs at reset values, subsequent 02 00 09 commits wf[7:0]=09 with upd=2'b01.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared definitions for the DDS command controller.
//   - command codes for the UART framing (SETFREQ, SETWF)
//   - parser state enum
//   - is_cmd(): recognises a valid command byte
// Optional feature macro: CMD_CHECKSUM_EN adds the trailing checksum state.
package dds_ctrl_pkg;

  localparam logic [7:0] CMD_SETFREQ = 8'h01;
  localparam logic [7:0] CMD_SETWF   = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHAN,
    ST_WAVE,
`ifdef CMD_CHECKSUM_EN
    ST_ACC,
    ST_CHK
`else
    ST_ACC
`endif
  } parse_state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_SETFREQ) || (b == CMD_SETWF);
  endfunction

endpackage

// File: rtl/dds_byte_timer.sv
// dds_byte_timer: inter-byte timeout for the command parser.
// Down-counter loaded on clear; expired is high while running and the
// count has reached zero, i.e. TIMEOUT_CYC cycles after the last clear.
//   clk     : clock
//   rst     : asynchronous active-low reset
//   clear   : reload the counter (a byte was accepted)
//   run     : count while a frame is in progress
//   expired : terminal count reached while running
module dds_byte_timer #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  // Loading TIMEOUT_CYC-1 makes the terminal count land on the
  // TIMEOUT_CYC-th cycle after the byte that cleared it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CNT_W'(TIMEOUT_CYC - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/dds_cmd_ctrl.sv
// dds_cmd_ctrl: UART byte-stream command parser driving per-channel DDS
// waveform select and phase-accumulator adder values.
// Frame: CMD, CH, WF, [ACC_W/8 adder bytes MSB first for SETFREQ], [CHK].
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   rx_data, rx_valid : received byte and its one-cycle strobe
//   wf                : CHANNELS x 8-bit waveform select, channel n at [8n+7:8n]
//   adder             : CHANNELS x ACC_W adder values
//   upd               : one-cycle per-channel commit pulse
//   err               : one-cycle frame-error pulse (bad channel, bad CHK, timeout)
//   busy              : frame in progress
// Optional feature macro: CMD_CHECKSUM_EN (trailing XOR checksum byte).
//
// state | meaning
// IDLE  | waiting for a valid command byte, other bytes ignored
// CHAN  | waiting for channel byte
// WAVE  | waiting for waveform byte
// ACC   | collecting adder bytes (SETFREQ only)
// CHK   | waiting for checksum byte (CMD_CHECKSUM_EN only)
module dds_cmd_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 32,
  parameter int ADDER_RST   = 1073741,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [CHANNELS*8-1:0]     wf,
  output logic [CHANNELS*ACC_W-1:0] adder,
  output logic [CHANNELS-1:0]       upd,
  output logic                      err,
  output logic                      busy
);

  localparam int NB   = ACC_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);

  parse_state_t state, state_nxt;

  logic [CHANNELS-1:0][7:0]       wf_r;
  logic [CHANNELS-1:0][ACC_W-1:0] adder_r;
  logic [7:0]       cmd_sh, ch_sh, wf_sh, wf_fin;
  logic [ACC_W-1:0] acc_sh, acc_shift, acc_fin;
  logic [BC_W-1:0]  bcnt;
  logic accept, data_done, finish, timeout, expired, chk_ok, frame_ok;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] xor_sh;
`endif

  dds_byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .run     (state != ST_IDLE),
    .expired (expired)
  );

  assign wf    = wf_r;
  assign adder = adder_r;
  assign busy  = (state != ST_IDLE);

  // Without a checksum byte the frame ends on the WF or last adder byte,
  // so the committed value must include the byte arriving this cycle.
  assign acc_shift = (acc_sh << 8) | ACC_W'(rx_data);
  assign wf_fin    = (state == ST_WAVE) ? rx_data : wf_sh;
  assign acc_fin   = (state == ST_ACC) ? acc_shift : acc_sh;
`ifdef CMD_CHECKSUM_EN
  assign chk_ok = (rx_data == xor_sh);
`else
  assign chk_ok = 1'b1;
`endif
  assign frame_ok = (ch_sh < 8'(CHANNELS)) && chk_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    data_done = 1'b0;
    finish    = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: if (rx_valid && is_cmd(rx_data)) begin
        accept    = 1'b1;
        state_nxt = ST_CHAN;
      end
      ST_CHAN: if (rx_valid) begin
        accept    = 1'b1;
        state_nxt = ST_WAVE;
      end
      ST_WAVE: if (rx_valid) begin
        accept = 1'b1;
        if (cmd_sh == CMD_SETFREQ) state_nxt = ST_ACC;
        else                       data_done = 1'b1;
      end
      ST_ACC: if (rx_valid) begin
        accept = 1'b1;
        if (bcnt == BC_LAST) data_done = 1'b1;
      end
`ifdef CMD_CHECKSUM_EN
      ST_CHK: if (rx_valid) begin
        accept    = 1'b1;
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
    if (data_done) begin
`ifdef CMD_CHECKSUM_EN
      state_nxt = ST_CHK;
`else
      finish    = 1'b1;
      state_nxt = ST_IDLE;
`endif
    end
    // A byte arriving on the expiry cycle wins over the timeout.
    if ((state != ST_IDLE) && !rx_valid && expired) begin
      timeout   = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wf_r    <= '0;
      adder_r <= {CHANNELS{ACC_W'(ADDER_RST)}};
      upd     <= '0;
      err     <= 1'b0;
      cmd_sh  <= '0;
      ch_sh   <= '0;
      wf_sh   <= '0;
      acc_sh  <= '0;
      bcnt    <= '0;
`ifdef CMD_CHECKSUM_EN
      xor_sh  <= '0;
`endif
    end else begin
      upd <= '0;
      err <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: cmd_sh <= rx_data;
          ST_CHAN: ch_sh  <= rx_data;
          ST_WAVE: begin
            wf_sh <= rx_data;
            bcnt  <= '0;
          end
          ST_ACC: begin
            acc_sh <= acc_shift;
            bcnt   <= bcnt + BC_W'(1);
          end
          default: ;
        endcase
`ifdef CMD_CHECKSUM_EN
        xor_sh <= (state == ST_IDLE) ? rx_data : (xor_sh ^ rx_data);
`endif
      end
      if (finish) begin
        if (frame_ok) begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (ch_sh == 8'(n)) begin
              wf_r[n] <= wf_fin;
              if (cmd_sh == CMD_SETFREQ) adder_r[n] <= acc_fin;
              upd[n] <= 1'b1;
            end
          end
        end else begin
          err <= 1'b1;
        end
      end
      if (timeout) err <= 1'b1;
      // Shadow data never outlives its frame.
      if (finish || timeout) begin
        cmd_sh <= '0;
        ch_sh  <= '0;
        wf_sh  <= '0;
        acc_sh <= '0;
        bcnt   <= '0;
`ifdef CMD_CHECKSUM_EN
        xor_sh <= '0;
`endif
      end
    end
  end

endmodule
